// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Converter FSM state, display limit and BCD nibble width.
package seg_pkg;
  typedef enum logic {
    IDLE,
    CONVERT
  } conv_state_t;

  localparam logic [31:0] DISP_MAX = 32'd9999;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift per cycle.
// Ports: clk, rst, value/load in; busy, overflow, bcd out.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           value,
  input  logic                       load,
  output logic                       busy,
  output logic                       overflow,
  output logic [DIGITS*NIBBLE_W-1:0] bcd
);
  localparam int BCD_W = DIGITS * NIBBLE_W;
  localparam int CNT_W = $clog2(WIDTH + 1);

  conv_state_t      state;
  conv_state_t      state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scratch_nx;
  logic [CNT_W-1:0] iter;
  logic             sat;
  logic             last;

  assign busy = (state == CONVERT);
  assign last = (iter == CNT_W'(WIDTH - 1));

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*NIBBLE_W +: NIBBLE_W] >= 4'd5)
        adj[i*NIBBLE_W +: NIBBLE_W] =
          scratch[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
    end
    scratch_nx = {adj[BCD_W-2:0], shreg[WIDTH-1]};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load) state_nx = CONVERT;
      CONVERT: if (last) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Saturation is decided on the captured value, so the
  // truncated 5th BCD digit in scratch never matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      scratch  <= '0;
      iter     <= '0;
      sat      <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            shreg   <= value;
            scratch <= '0;
            iter    <= '0;
            sat     <= (32'(value) > DISP_MAX);
          end
        end
        CONVERT: begin
          shreg   <= shreg << 1;
          scratch <= scratch_nx;
          iter    <= iter + CNT_W'(1);
          if (last) begin
            bcd      <= sat ? {DIGITS{4'd9}} : scratch_nx;
            overflow <= sat;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD feeder that scans digits onto one shared decoder.
// Ports: clk, rst, value, load; busy, overflow, digit_data, digit_en.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic                overflow,
  output logic [3:0]          digit_data,
  output logic [DIGITS-1:0]   digit_en
);
  localparam int BCD_W = DIGITS * NIBBLE_W;
  localparam int CW    = $clog2(REFRESH_DIV);
  localparam int IW    = $clog2(DIGITS);

  logic [BCD_W-1:0]  bcd;
  logic [CW-1:0]     rcnt;
  logic [IW-1:0]     idx;
  logic              tc;
  logic [3:0]        nib;
  logic              hi_zero;
  logic [DIGITS-1:0] en_nx;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .bcd      (bcd)
  );

  assign tc = (rcnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (tc) begin
      rcnt <= '0;
      idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      rcnt <= rcnt + CW'(1);
    end
  end

  // A digit is a leading zero when it and every higher
  // nibble are zero; digit 0 always stays lit.
  always_comb begin
    nib     = bcd[int'(idx)*NIBBLE_W +: NIBBLE_W];
    hi_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx) && bcd[i*NIBBLE_W +: NIBBLE_W] != 4'd0)
        hi_zero = 1'b0;
    end
    en_nx = ~(DIGITS'(1) << idx);
    if (BLANK_LZ != 0 && idx != '0 && hi_zero)
      en_nx = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_data <= 4'd0;
      digit_en   <= ~DIGITS'(1);
    end else begin
      digit_data <= nib;
      digit_en   <= en_nx;
    end
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Upstream feeder for the 7-segment decoder. It takes a binary value on a load strobe and converts it to 4 BCD digits using a sequential double-dabble (shift-add-3) engine. It then time-multiplexes those digits onto one shared decoder: one 4-bit nibble goes to the decoder's data input, and an active-low digit-enable vector drives the common anodes.

Parameters:
- WIDTH, 14, binary input width; conversion takes WIDTH cycles.
- DIGITS, 4, number of display digits. Fixed at 4 in this revision.
- REFRESH_DIV, 50000, clk cycles each digit stays lit. Must be ≥2.
- BLANK_LZ, 1, when 1, leading-zero digits are disabled. Digit 0 is never blanked.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- value, input, WIDTH, binary number to display; sampled only on an accepted load.
- load, input, 1, one-cycle strobe requesting a conversion.
- busy, output, 1, high while a conversion is in progress.
- overflow, output, 1, high when the last accepted value was >9999.
- digit_data, output, 4, BCD nibble of the currently scanned digit; connects to the decoder's data input.
- digit_en, output, DIGITS, active-low enable; bit i low lights digit i (digit 0 = units).

Behaviour:
- **Reset** (rst high at an edge), applied on that edge:
  - busy=0, overflow=0, bcd register=0.
  - Scan index=0, refresh counter=0.
  - digit_data=4'd0, digit_en=4'b1110.
  - Any conversion in flight is aborted and its result discarded.
- **Converter FSM**, states IDLE and CONVERT:
  - IDLE: load=1 captures value into a shift register and clears the BCD scratch register. It moves to CONVERT with busy=1 from the next cycle.
  - CONVERT: runs exactly WIDTH iterations, one per cycle. In each iteration, every scratch nibble ≥5 gets +3, then the combined {scratch, shift} register shifts left by 1.
  - Completion: on the edge ending the WIDTH-th iteration, the FSM returns to IDLE and busy falls. On that same edge the bcd register and overflow update atomically.
  - Latency: a load accepted at edge N produces busy=1 for cycles N+1..N+WIDTH, and the new bcd is visible after edge N+WIDTH.
  - Saturation: if the captured value >9999, bcd becomes 9,9,9,9 and overflow=1. Otherwise the converted digits are stored and overflow=0. The comparison is made on the captured value.
  - load while busy=1 is ignored; no queueing.
  - The display keeps showing the previous bcd for the whole conversion.
- **Scanner**, free-running and independent of the FSM:
  - The refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances (mod DIGITS): 3 wraps to 0.
  - digit_data and digit_en are registered outputs. They reflect the scan index and bcd one cycle after the index changes.
  - digit_en = all ones except bit idx, which is 0.
  - Leading-zero blanking (BLANK_LZ=1): digit i>0 is blanked (digit_en all ones) when nibbles i..DIGITS-1 are all zero. digit_data still shows the nibble.
  - If a bcd update and an index advance happen on the same edge, the output on the next cycle uses the new bcd.
- **Non-BCD nibbles**: none are ever produced, so the decoder's default branch is unreachable.

Decomposition:
- Shared package seg_pkg:
  - converter state enum {IDLE, CONVERT}
  - localparam DISP_MAX = 9999
  - localparam NIBBLE_W = 4
- Sub-module bin2bcd_seq: owns the converter FSM and the bcd/overflow/busy registers.
- The top level holds the refresh counter, scan index, blanking logic and output registers.

Test Plan (simulate with REFRESH_DIV=4):
1. **Reset:** assert rst for 2 cycles → busy=0, overflow=0, digit_en=4'b1110, digit_data=0. Then digit_en rotates 1110→(blanked)… every 4 cycles and digit 0 stays lit with 0.
2. **Load 1234:** load with value=1234 → busy high for 14 cycles and low on the 15th. Over the following scan, digit_data/digit_en pairs are (4,1110), (3,1101), (2,1011), (1,0111); overflow=0.
3. **Saturation:** load 10000 → after conversion all four digits show 9 and overflow=1. Then load 42 → overflow=0 and the display reads 0042 with digits 2 and 3 blanked.
4. **Blanking:** load 7 with BLANK_LZ=1 → only digit_en=1110 ever appears, with data 7. With BLANK_LZ=0, all four digits are enabled and show 0,0,0,7.
5. **Load during busy:** load 5000, then pulse load with 1111 at cycle +5 → busy still drops after 14 cycles and the display shows 5000.
6. **Reset mid-conversion:** load 9876, assert rst at cycle +7 → busy=0, bcd=0, display shows 0. A load of 321 after reset converts normally.
